// File: rtl/rxframe_pkg.sv
// Shared USRT definitions: parity mode encodings, frame bit positions and
// receiver state encodings used by both ends of the link.
package usrt_defs;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  // Bit positions inside a full 11-bit frame (parity slot absent in 10-bit frames).
  localparam int START_POS  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_POS = 9;
  localparam int STOP_POS   = 10;
  localparam int FRAME_W    = 11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_DATA   = 2'b01;
  localparam logic [1:0] ST_PARITY = 2'b10;
  localparam logic [1:0] ST_STOP   = 2'b11;

  typedef logic [1:0] par_mode_t;

  function automatic logic par_enabled(input par_mode_t mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/rxframe_parity_calc.sv
// Expected-parity generator shared by the receiver and the transmit framer.
// None and reserved modes yield 0.
module parity_calc
  import usrt_defs::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        i_Mode,
  input  logic [DATA_W-1:0] i_Data,
  output logic              o_Exp_Par
);

  always_comb begin
    o_Exp_Par = 1'b0;
    case (i_Mode)
      PAR_ODD:  o_Exp_Par = ~^i_Data;
      PAR_EVEN: o_Exp_Par = ^i_Data;
      default:  o_Exp_Par = 1'b0;
    endcase
  end

endmodule

// File: rtl/rxframe.sv
// USRT frame receiver: one line bit per clock, LSB-first data, optional
// parity, stop check, and a one-cycle valid strobe with error flags.
module rxframe
  import usrt_defs::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Rst_n,
  input  logic              i_Serial,
  input  logic [1:0]        i_Parity,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Valid,
  output logic              o_Parity_Err,
  output logic              o_Frame_Err,
  output logic              o_Busy,
  output logic [1:0]        o_Dbg_State
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              valid_q, valid_d;
  logic              exp_par;

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .i_Mode    (mode_q),
    .i_Data    (shift_q),
    .o_Exp_Par (exp_par)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Mode is latched here so mid-frame changes on i_Parity are ignored.
        if (!i_Serial) begin
          state_d = ST_DATA;
          mode_d  = i_Parity;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        shift_d[cnt_q] = i_Serial;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        par_bit_d = i_Serial;
        state_d   = ST_STOP;
      end
      ST_STOP: begin
        // A bad stop bit still delivers the byte; no stop-bit hunting.
        data_d  = shift_q;
        perr_d  = par_enabled(mode_q) && (par_bit_q != exp_par);
        ferr_d  = ~i_Serial;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= PAR_NONE;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
    end
  end

  assign o_Data       = data_q;
  assign o_Valid      = valid_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Dbg_State  = state_q;

endmodule

// File: tb/tb_rxframe.sv
// Directed bench for rxframe: frames are driven bit by bit, expected bytes and
// flags are queued at issue time and checked by a monitor on each o_Valid.
module tb_rxframe;
  import usrt_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial;
  logic [1:0] par_mode;
  logic [7:0] o_data;
  logic       o_valid, o_perr, o_ferr, o_busy;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [9:0] exp_q[$];
  int valid_cyc[$];

  rxframe #(.DATA_W(8)) dut (
    .i_Pclk       (clk),
    .i_Rst_n      (rst_n),
    .i_Serial     (serial),
    .i_Parity     (par_mode),
    .o_Data       (o_data),
    .o_Valid      (o_valid),
    .o_Parity_Err (o_perr),
    .o_Frame_Err  (o_ferr),
    .o_Busy       (o_busy),
    .o_Dbg_State  (o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1) begin
      logic [9:0] e;
      valid_cyc.push_back(cyc);
      check("busy_low_at_valid", {31'd0, o_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, o_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", {24'd0, o_data}, {24'd0, e[9:2]});
        check("parity_err", {31'd0, o_perr}, {31'd0, e[1]});
        check("frame_err", {31'd0, o_ferr}, {31'd0, e[0]});
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      serial = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic [1:0] mode_after, input logic pbit,
                            input logic stop, input logic e_perr, input logic e_ferr);
    exp_q.push_back({d, e_perr, e_ferr});
    @(negedge clk);
    par_mode = mode;
    serial   = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    par_mode = mode_after;
    serial   = d[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      serial = d[i];
    end
    if (mode == PAR_ODD || mode == PAR_EVEN) begin
      @(negedge clk);
      serial = pbit;
    end
    @(negedge clk);
    serial = stop;
  endtask

  initial begin
    logic [7:0] d5a;
    int base;
    rst_n    = 1'b0;
    serial   = 1'b1;
    par_mode = PAR_NONE;
    #22;
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_perr", {31'd0, o_perr}, 32'd0);
    check("rst_ferr", {31'd0, o_ferr}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Odd 8'h03, parity 1: clean
    send_frame(8'h03, PAR_ODD, PAR_ODD, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Even 8'h07 with wrong parity bit 0
    send_frame(8'h07, PAR_EVEN, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // No parity, 8'hA5 with stop 0, then a start right away
    send_frame(8'hA5, PAR_NONE, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, PAR_NONE, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back odd frames
    base = valid_cyc.size();
    send_frame(8'h03, PAR_ODD, PAR_ODD, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, PAR_ODD, PAR_ODD, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("b2b_count", 32'(valid_cyc.size() - base), 32'd2);
    if (valid_cyc.size() - base == 2)
      check("b2b_spacing", 32'(valid_cyc[base+1] - valid_cyc[base]), 32'(FRAME_W));

    // Mode switched mid-frame: latched odd mode applies
    send_frame(8'h03, PAR_ODD, PAR_EVEN, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // Reserved mode behaves as none: 10-bit frame, no parity error
    send_frame(8'hF0, PAR_RSVD, PAR_RSVD, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset pulsed at data bit 4
    d5a  = 8'h5A;
    base = valid_cyc.size();
    @(negedge clk);
    par_mode = PAR_ODD;
    serial   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      serial = d5a[i];
    end
    @(negedge clk);
    check("busy_mid_frame", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, o_data}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    serial = 1'b1;
    rst_n  = 1'b1;
    idle(2);
    check("no_valid_after_reset", 32'(valid_cyc.size() - base), 32'd0);
    send_frame(8'h5A, PAR_EVEN, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
